// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

    typedef enum logic [2:0] {
        BOOT  = 3'd0,
        REQ   = 3'd1,
        WAIT  = 3'd2,
        HELD  = 3'd3,
        DRAIN = 3'd4
    } fetch_state_e;

    localparam logic [31:0] NOP_INSTR  = 32'h0000_0000;
    localparam logic [31:0] PC_STEP    = 32'd4;
    localparam logic [31:0] R15_OFFSET = 32'd8;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_skid.sv
// One-entry {instr, pc} buffer that parks a response arriving while decode is stalled.
module fetch_skid (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic        clear,
    input  logic [31:0] load_instr,
    input  logic [31:0] load_pc,
    output logic [31:0] instr,
    output logic [31:0] pc,
    output logic        valid
);

    // NOTE: clocked state uses non-blocking (<=) so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid <= 1'b0;
        end else if (clear) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
        end
    end

    // NOTE: only the valid flag needs a reset; the payload is never read while valid is low.
    always_ff @(posedge clk) begin
        if (load) begin
            instr <= load_instr;
            pc    <= load_pc;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns PCF, runs the imem request/grant/valid handshake
// and loads the IF/ID register, discarding responses made stale by a redirect.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        StallF,
    input  logic        StallD,
    input  logic        FlushD,
    input  logic        BranchTakenE,
    input  logic [31:0] BranchTargetE,
    input  logic        PCSrcW,
    input  logic [31:0] ResultW,
    output logic        ImemReq,
    output logic [31:0] ImemAddr,
    input  logic        ImemGnt,
    input  logic        ImemValid,
    input  logic [31:0] ImemRdata,
    output logic [31:0] InstrD,
    output logic [31:0] PCD,
    output logic [31:0] PCPlus8D,
    output logic        ValidD
);

    fetch_state_e state, state_next;
    logic [31:0]  pcf, pcf_next;
    logic         redirect;
    logic [31:0]  redirect_target;
    logic         load_mem;
    logic         load_skid;
    logic         skid_load;
    logic         skid_clear;
    logic [31:0]  skid_instr;
    logic [31:0]  skid_pc;
    logic         skid_valid;

    assign redirect        = BranchTakenE | PCSrcW;
    assign redirect_target = word_align(BranchTakenE ? BranchTargetE : ResultW);
    assign ImemAddr        = pcf;

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_next = state;
        pcf_next   = pcf;
        ImemReq    = 1'b0;
        load_mem   = 1'b0;
        load_skid  = 1'b0;
        skid_load  = 1'b0;
        skid_clear = 1'b0;
        case (state)
            BOOT: state_next = REQ;
            REQ: begin
                ImemReq = !StallF;
                if (redirect) pcf_next = redirect_target;
                if (ImemReq && ImemGnt) state_next = redirect ? DRAIN : WAIT;
            end
            WAIT: begin
                if (ImemValid) begin
                    if (redirect) begin
                        pcf_next   = redirect_target;
                        state_next = REQ;
                    end else if (!StallD) begin
                        load_mem   = 1'b1;
                        pcf_next   = pcf + PC_STEP;
                        state_next = REQ;
                    end else begin
                        skid_load  = 1'b1;
                        state_next = HELD;
                    end
                end else if (redirect) begin
                    pcf_next   = redirect_target;
                    state_next = DRAIN;
                end
            end
            HELD: begin
                if (redirect) begin
                    skid_clear = 1'b1;
                    pcf_next   = redirect_target;
                    state_next = REQ;
                end else if (!StallD && skid_valid) begin
                    load_skid  = 1'b1;
                    skid_clear = 1'b1;
                    pcf_next   = pcf + PC_STEP;
                    state_next = REQ;
                end
            end
            DRAIN: begin
                // The stale response must still be absorbed before a new request goes out.
                if (redirect) pcf_next = redirect_target;
                if (ImemValid) state_next = REQ;
            end
            default: state_next = BOOT;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= BOOT;
            pcf   <= RESET_PC;
        end else begin
            state <= state_next;
            pcf   <= pcf_next;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            InstrD   <= NOP_INSTR;
            PCD      <= 32'h0;
            PCPlus8D <= R15_OFFSET;
            ValidD   <= 1'b0;
        end else if (FlushD) begin
            InstrD <= NOP_INSTR;
            ValidD <= 1'b0;
        end else if (!StallD) begin
            if (load_mem) begin
                InstrD   <= ImemRdata;
                PCD      <= pcf;
                PCPlus8D <= pcf + R15_OFFSET;
                ValidD   <= 1'b1;
            end else if (load_skid) begin
                InstrD   <= skid_instr;
                PCD      <= skid_pc;
                PCPlus8D <= skid_pc + R15_OFFSET;
                ValidD   <= 1'b1;
            end else begin
                ValidD <= 1'b0;
            end
        end
    end

    fetch_skid u_skid (
        .clk        (clk),
        .reset      (reset),
        .load       (skid_load),
        .clear      (skid_clear),
        .load_instr (ImemRdata),
        .load_pc    (pcf),
        .instr      (skid_instr),
        .pc         (skid_pc),
        .valid      (skid_valid)
    );

endmodule

// File: tb/tb_fetch_stage.sv
// Directed, table-driven bench for fetch_stage against a small instruction-memory model.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        StallF, StallD, FlushD;
    logic        BranchTakenE, PCSrcW;
    logic [31:0] BranchTargetE, ResultW;
    logic        ImemReq, ImemGnt, ImemValid;
    logic [31:0] ImemAddr, ImemRdata;
    logic [31:0] InstrD, PCD, PCPlus8D;
    logic        ValidD;

    localparam logic [31:0] I00  = 32'hE3A01005;
    localparam logic [31:0] I04  = 32'hE2811001;
    localparam logic [31:0] I08  = 32'hE0800001;
    localparam logic [31:0] I40  = 32'hE3A0200A;
    localparam logic [31:0] I44  = 32'hE3A03001;
    localparam logic [31:0] I80  = 32'hE3A04007;
    localparam logic [31:0] I100 = 32'hE3A05009;
    localparam logic [31:0] I104 = 32'hE3A0600B;
    localparam logic [31:0] I108 = 32'hE3A0700D;

    fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
        .clk           (clk),
        .reset         (reset),
        .StallF        (StallF),
        .StallD        (StallD),
        .FlushD        (FlushD),
        .BranchTakenE  (BranchTakenE),
        .BranchTargetE (BranchTargetE),
        .PCSrcW        (PCSrcW),
        .ResultW       (ResultW),
        .ImemReq       (ImemReq),
        .ImemAddr      (ImemAddr),
        .ImemGnt       (ImemGnt),
        .ImemValid     (ImemValid),
        .ImemRdata     (ImemRdata),
        .InstrD        (InstrD),
        .PCD           (PCD),
        .PCPlus8D      (PCPlus8D),
        .ValidD        (ValidD)
    );

    always #5 clk = ~clk;

    // Memory model: grants immediately, answers 'lat' cycles after the grant.
    logic [31:0] imem [0:127];
    logic [31:0] pend_addr;
    int          cnt;
    int          lat;
    int          proto_err;

    assign ImemGnt   = ImemReq;
    assign ImemValid = (cnt == 1);
    assign ImemRdata = imem[pend_addr[8:2]];

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt       <= 0;
            pend_addr <= 32'h0;
        end else if (ImemReq && ImemGnt) begin
            cnt       <= lat;
            pend_addr <= ImemAddr;
        end else if (cnt != 0) begin
            cnt <= cnt - 1;
        end
    end

    always @(negedge clk) begin
        if (!reset && ImemReq && cnt != 0) proto_err <= proto_err + 1;
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        sf, sd, fd, br, pw;
        logic [31:0] bt, rw;
        int          lat;
        logic        req;
        logic [31:0] addr;
        logic        valid;
        logic [31:0] instr, pcd, pc8;
    } vec_t;

    vec_t vecs [1:32];

    function automatic vec_t mk(input logic sf, sd, fd, br, input logic [31:0] bt,
                                input logic pw, input logic [31:0] rw, input int l,
                                input logic req, input logic [31:0] addr, input logic valid,
                                input logic [31:0] instr, pcd, pc8);
        vec_t v;
        v.sf = sf; v.sd = sd; v.fd = fd; v.br = br; v.bt = bt; v.pw = pw; v.rw = rw;
        v.lat = l; v.req = req; v.addr = addr; v.valid = valid;
        v.instr = instr; v.pcd = pcd; v.pc8 = pc8;
        return v;
    endfunction

    task automatic check_outputs(input string tag, input logic req, input logic [31:0] addr,
                                 input logic valid, input logic [31:0] instr, pcd, pc8);
        check({tag, " ImemReq"},  {31'h0, ImemReq}, {31'h0, req});
        check({tag, " ImemAddr"}, ImemAddr, addr);
        check({tag, " ValidD"},   {31'h0, ValidD}, {31'h0, valid});
        check({tag, " InstrD"},   InstrD, instr);
        check({tag, " PCD"},      PCD, pcd);
        check({tag, " PCPlus8D"}, PCPlus8D, pc8);
    endtask

    task automatic drive_idle();
        StallF = 0; StallD = 0; FlushD = 0;
        BranchTakenE = 0; BranchTargetE = 32'h0;
        PCSrcW = 0; ResultW = 32'h0;
    endtask

    initial begin
        for (int i = 0; i < 128; i++) imem[i] = 32'hDEAD_0000 | i;
        imem[0]  = I00;  imem[1]  = I04;  imem[2]  = I08;
        imem[16] = I40;  imem[17] = I44;  imem[32] = I80;
        imem[64] = I100; imem[65] = I104; imem[66] = I108;

        //         sf sd fd br bt      pw rw       lat req addr       v  instr pcd      pc8
        vecs[1]  = mk(0, 0, 0, 0, 32'h0,  0, 32'h0,   1, 1, 32'h0,   0, 32'h0, 32'h0,   32'h8);
        vecs[2]  = mk(0, 0, 0, 0, 32'h0,  0, 32'h0,   1, 0, 32'h0,   0, 32'h0, 32'h0,   32'h8);
        vecs[3]  = mk(0, 0, 0, 0, 32'h0,  0, 32'h0,   1, 1, 32'h4,   1, I00,   32'h0,   32'h8);
        vecs[4]  = mk(0, 1, 0, 0, 32'h0,  0, 32'h0,   1, 0, 32'h4,   0, I00,   32'h0,   32'h8);
        vecs[5]  = mk(0, 1, 0, 0, 32'h0,  0, 32'h0,   1, 0, 32'h4,   0, I00,   32'h0,   32'h8);
        vecs[6]  = mk(0, 1, 0, 0, 32'h0,  0, 32'h0,   1, 0, 32'h4,   0, I00,   32'h0,   32'h8);
        vecs[7]  = mk(0, 0, 0, 0, 32'h0,  0, 32'h0,   1, 0, 32'h4,   0, I00,   32'h0,   32'h8);
        vecs[8]  = mk(0, 0, 0, 0, 32'h0,  0, 32'h0,   1, 1, 32'h8,   1, I04,   32'h4,   32'hC);
        vecs[9]  = mk(0, 0, 0, 1, 32'h40, 0, 32'h0,   1, 0, 32'h8,   0, I04,   32'h4,   32'hC);
        vecs[10] = mk(0, 0, 0, 0, 32'h0,  0, 32'h0,   1, 1, 32'h40,  0, I04,   32'h4,   32'hC);
        vecs[11] = mk(0, 0, 0, 0, 32'h0,  0, 32'h0,   1, 0, 32'h40,  0, I04,   32'h4,   32'hC);
        vecs[12] = mk(0, 0, 0, 0, 32'h0,  0, 32'h0,   2, 1, 32'h44,  1, I40,   32'h40,  32'h48);
        vecs[13] = mk(0, 0, 0, 1, 32'h80, 1, 32'h100, 2, 0, 32'h44,  0, I40,   32'h40,  32'h48);
        vecs[14] = mk(0, 0, 0, 0, 32'h0,  0, 32'h0,   1, 0, 32'h80,  0, I40,   32'h40,  32'h48);
        vecs[15] = mk(0, 0, 0, 0, 32'h0,  0, 32'h0,   1, 1, 32'h80,  0, I40,   32'h40,  32'h48);
        vecs[16] = mk(0, 0, 0, 0, 32'h0,  0, 32'h0,   1, 0, 32'h80,  0, I40,   32'h40,  32'h48);
        vecs[17] = mk(1, 0, 0, 0, 32'h0,  1, 32'h103, 1, 0, 32'h84,  1, I80,   32'h80,  32'h88);
        vecs[18] = mk(0, 0, 0, 0, 32'h0,  0, 32'h0,   1, 1, 32'h100, 0, I80,   32'h80,  32'h88);
        vecs[19] = mk(0, 1, 1, 0, 32'h0,  0, 32'h0,   1, 0, 32'h100, 0, I80,   32'h80,  32'h88);
        vecs[20] = mk(0, 0, 0, 0, 32'h0,  0, 32'h0,   1, 0, 32'h100, 0, 32'h0, 32'h80,  32'h88);
        vecs[21] = mk(0, 1, 1, 0, 32'h0,  0, 32'h0,   1, 1, 32'h104, 1, I100,  32'h100, 32'h108);
        vecs[22] = mk(0, 0, 0, 0, 32'h0,  0, 32'h0,   1, 0, 32'h104, 0, 32'h0, 32'h100, 32'h108);
        vecs[23] = mk(0, 0, 0, 0, 32'h0,  0, 32'h0,   1, 1, 32'h108, 1, I104,  32'h104, 32'h10C);
        vecs[24] = mk(0, 1, 0, 0, 32'h0,  0, 32'h0,   1, 0, 32'h108, 0, I104,  32'h104, 32'h10C);
        vecs[25] = mk(0, 1, 0, 1, 32'h40, 0, 32'h0,   1, 0, 32'h108, 0, I104,  32'h104, 32'h10C);
        vecs[26] = mk(0, 0, 0, 0, 32'h0,  0, 32'h0,   1, 1, 32'h40,  0, I104,  32'h104, 32'h10C);
        vecs[27] = mk(0, 0, 0, 0, 32'h0,  0, 32'h0,   1, 0, 32'h40,  0, I104,  32'h104, 32'h10C);
        vecs[28] = mk(0, 0, 0, 1, 32'h0,  0, 32'h0,   1, 1, 32'h44,  1, I40,   32'h40,  32'h48);
        vecs[29] = mk(0, 0, 0, 0, 32'h0,  0, 32'h0,   1, 0, 32'h0,   0, I40,   32'h40,  32'h48);
        vecs[30] = mk(0, 0, 0, 0, 32'h0,  0, 32'h0,   1, 1, 32'h0,   0, I40,   32'h40,  32'h48);
        vecs[31] = mk(0, 0, 0, 0, 32'h0,  0, 32'h0,   1, 0, 32'h0,   0, I40,   32'h40,  32'h48);
        vecs[32] = mk(0, 0, 0, 0, 32'h0,  0, 32'h0,   2, 1, 32'h4,   1, I00,   32'h0,   32'h8);

        proto_err = 0;
        lat       = 1;
        drive_idle();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check_outputs("reset", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 32'h8);

        // Step k samples after edge k with step-k inputs applied; they act on edge k+1.
        @(negedge clk);
        reset = 1'b0;
        for (int k = 1; k <= 32; k++) begin
            @(negedge clk);
            StallF = vecs[k].sf; StallD = vecs[k].sd; FlushD = vecs[k].fd;
            BranchTakenE = vecs[k].br; BranchTargetE = vecs[k].bt;
            PCSrcW = vecs[k].pw; ResultW = vecs[k].rw;
            lat = vecs[k].lat;
            #1;
            check_outputs($sformatf("step%0d", k), vecs[k].req, vecs[k].addr,
                          vecs[k].valid, vecs[k].instr, vecs[k].pcd, vecs[k].pc8);
        end

        // Async reset while a 2-cycle response to 0x4 is still outstanding.
        @(negedge clk);
        drive_idle();
        #1;
        check({"midwait ImemReq"}, {31'h0, ImemReq}, 32'h0);
        check({"midwait ImemAddr"}, ImemAddr, 32'h4);
        reset = 1'b1;
        #1;
        check_outputs("async_reset", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 32'h8);
        lat = 1;
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("restart edge2 ValidD", {31'h0, ValidD}, 32'h0);
        @(posedge clk);
        #1;
        check_outputs("restart edge3", 1'b1, 32'h4, 1'b1, I00, 32'h0, 32'h8);

        repeat (2) @(negedge clk);
        check("protocol req while outstanding", proto_err, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the pipelined ARM core: owns the fetch PC, issues word requests to instruction memory over a request/grant/valid handshake, and loads the IF/ID pipeline register whose `InstrD[23:0]` field feeds the immediate extender in decode. It handles stalls from the hazard unit, PC redirects from execute (`BranchTakenE`) and writeback (`PCSrcW`), and discards in-flight responses made stale by a redirect.

## Interface
- `RESET_PC`, 32'h0000_0000, PC loaded on reset
- `clk`  in  1  core clock; all state updates on rising edge
- `reset`  in  1  asynchronous, active-high reset
- `StallF`  in  1  hazard unit: do not advance PCF or issue a new request
- `StallD`  in  1  hazard unit: hold IF/ID register
- `FlushD`  in  1  hazard unit: clear IF/ID register
- `BranchTakenE`  in  1  redirect from execute
- `BranchTargetE`  in  32  redirect target from execute
- `PCSrcW`  in  1  redirect from writeback (write to R15)
- `ResultW`  in  32  redirect target from writeback
- `ImemReq`  out  1  request valid
- `ImemAddr`  out  32  request word address (= PCF)
- `ImemGnt`  in  1  memory accepted request this cycle
- `ImemValid`  in  1  response data valid (≥1 cycle after grant, in order, one outstanding max)
- `ImemRdata`  in  32  response instruction
- `InstrD`  out  32  IF/ID instruction
- `PCD`  out  32  address of `InstrD`
- `PCPlus8D`  out  32  `PCD + 8` (architectural R15 read value)
- `ValidD`  out  1  IF/ID holds a real instruction

## Operation
- States: BOOT, REQ, WAIT, HELD, DRAIN.
- Reset (async): state=BOOT, PCF=`RESET_PC`, `InstrD`=0, `PCD`=0, `PCPlus8D`=8, `ValidD`=0, `ImemReq`=0, skid empty.
- BOOT: `ImemReq`=0; next edge → REQ.
- REQ: `ImemReq`=!`StallF`, `ImemAddr`=PCF. Grant with no redirect → WAIT.
- WAIT: on `ImemValid`: if !`StallD` load IF/ID {`ImemRdata`, PCF, PCF+8}, `ValidD`=1, PCF+=4, → REQ; if `StallD` capture into skid, → HELD.
- HELD: when !`StallD`, load IF/ID from skid, PCF+=4, → REQ.
- DRAIN: `ImemReq`=0; on `ImemValid` drop the data, → REQ.
- Redirect target: `BranchTakenE` ? `BranchTargetE` : `ResultW`; either asserted = redirect. Redirect overrides `StallF`; PCF←target at next edge in every state except BOOT (BOOT ignores redirects).
- Redirect by state: REQ no grant → REQ; REQ granted same cycle → DRAIN; WAIT without `ImemValid` → DRAIN; WAIT with `ImemValid` → data dropped, → REQ; HELD → skid cleared, → REQ.
- IF/ID priority: `FlushD` (`InstrD`=0, `ValidD`=0, PC fields keep) > `StallD` (hold) > load. Load with no new data while !`StallD`: `ValidD`←0.
- Block never self-flushes D; hazard unit asserts `FlushD` on redirect.
- PC arithmetic modulo 2^32; low two bits of target forced to 0.

## Timing
- Zero-wait memory (grant same cycle, valid next cycle): 2 cycles/instruction steady state.
- Reset release → first `ValidD`=1: 3 edges (BOOT, REQ, WAIT).
- Redirect asserted in cycle n → `ImemAddr`=target no earlier than cycle n+1 (n+2 when drain needed).
- `ImemReq` never asserted while a response is outstanding.
- Reset mid-WAIT: outstanding response after reset is ignored (BOOT does not consume; memory is reset by the same `reset`).

## Structure
- Package `fetch_pkg`: state enum, `NOP_INSTR`=32'h0, `PC_STEP`=4, `R15_OFFSET`=8.
- Sub-module `fetch_skid`: one-entry {instr, pc} buffer with load/clear/valid.

## Test plan
- Reset, zero-wait memory returning 0xE3A01005 at 0x0: `ValidD`=1 on edge 3, `InstrD`=0xE3A01005, `PCD`=0, `PCPlus8D`=8; next request `ImemAddr`=4.
- `StallD` high 3 cycles as response 0xE2811001 arrives: data held in skid, PCF frozen, IF/ID unchanged; on release `InstrD`=0xE2811001 one edge later.
- `BranchTakenE`=1, `BranchTargetE`=0x40 while in WAIT: next response discarded, following `ImemAddr`=0x40, 0x40's instruction reaches `InstrD`.
- `BranchTakenE` and `PCSrcW` both asserted (0x80 vs 0x100): PCF=0x80.
- `FlushD` and `StallD` together: `InstrD`=0, `ValidD`=0.
- Async `reset` pulse mid-WAIT: outputs at reset values immediately, restart at `RESET_PC`.
